// File: rtl/bitrev_buffer.sv
// bitrev_buffer: ping-pong reorder buffer that emits each frame of
// 2^LOG2N samples in bit-reversed or natural index order.
module bitrev_buffer #(
    parameter int LOG2N = 9,
    parameter int W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             rev_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last
);
    localparam int N = 1 << LOG2N;

    logic [W-1:0]     mem_q [2*N];
    logic [1:0]       full_q, full_d;
    logic [1:0]       mode_q, mode_d;
    logic             wbank_q, wbank_d;
    logic             rbank_q, rbank_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic [LOG2N-1:0] raddr;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [LOG2N-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             accept;
    logic             advance;
    logic             rd;

    assign in_ready = !full_q[wbank_q] && !reset;
    assign accept   = in_valid && in_ready;
    assign advance  = !out_valid_q || out_ready;
    assign rd       = advance && full_q[rbank_q];

    always_comb begin
        raddr = rcnt_q;
        if (mode_q[rbank_q]) begin
            for (int b = 0; b < LOG2N; b++) begin
                raddr[b] = rcnt_q[LOG2N-1-b];
            end
        end
    end

    // Writer and reader always own different banks, so their full-flag
    // updates never collide.
    always_comb begin
        full_d      = full_q;
        mode_d      = mode_q;
        wbank_d     = wbank_q;
        wcnt_d      = wcnt_q;
        rbank_d     = rbank_q;
        rcnt_d      = rcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        if (accept) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == '0) begin
                mode_d[wbank_q] = rev_en;
            end
            if (wcnt_q == '1) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end
        if (advance) begin
            out_valid_d = rd;
        end
        if (rd) begin
            out_data_d = mem_q[{rbank_q, raddr}];
            out_idx_d  = raddr;
            out_last_d = (rcnt_q == '1);
            rcnt_d     = rcnt_q + 1'b1;
            if (rcnt_q == '1) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[{wbank_q, wcnt_q}] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q      <= '0;
            mode_q      <= '0;
            wbank_q     <= 1'b0;
            wcnt_q      <= '0;
            rbank_q     <= 1'b0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            mode_q      <= mode_d;
            wbank_q     <= wbank_d;
            wcnt_q      <= wcnt_d;
            rbank_q     <= rbank_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_bitrev_buffer.sv
// tb_bitrev_buffer: scoreboard bench for bitrev_buffer with an 8-point
// and a 512-point instance against a frame-level reference model.
module tb_bitrev_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [31:0] in_data3 = '0;
    logic        rev3 = 1'b0;
    logic        out_valid3;
    logic        out_ready3 = 1'b1;
    logic [31:0] out_data3;
    logic [2:0]  out_idx3;
    logic        out_last3;

    logic        in_valid9 = 1'b0;
    logic        in_ready9;
    logic [31:0] in_data9 = '0;
    logic        rev9 = 1'b0;
    logic        out_valid9;
    logic        out_ready9 = 1'b1;
    logic [31:0] out_data9;
    logic [8:0]  out_idx9;
    logic        out_last9;

    always #5 clk = ~clk;

    bitrev_buffer #(.LOG2N(3), .W(32)) u3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .rev_en(rev3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_idx(out_idx3),
        .out_last(out_last3)
    );

    bitrev_buffer #(.LOG2N(9), .W(32)) u9 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid9), .in_ready(in_ready9),
        .in_data(in_data9), .rev_en(rev9),
        .out_valid(out_valid9), .out_ready(out_ready9),
        .out_data(out_data9), .out_idx(out_idx9),
        .out_last(out_last9)
    );

    typedef struct {
        logic [31:0] data;
        int          idx;
        logic        last;
    } exp_t;

    exp_t        q3[$];
    exp_t        q9[$];
    int          vecs = 0;
    int          errs = 0;
    logic [31:0] frm[2][512];
    int          fcnt[2];
    logic        frev[2];
    bit          rnd3 = 0;
    bit          rnd9 = 0;
    bit          gap_en = 0;
    bit          seen3 = 0;
    int          gaps = 0;
    int          waits3 = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int brev(int j, int l);
        int r = 0;
        for (int b = 0; b < l; b++) r = (r << 1) | ((j >> b) & 1);
        return r;
    endfunction

    // Frame-level reference: collect a whole frame, then list its words
    // in the order the consumer must see them.
    task automatic model_accept(int d, logic [31:0] v, logic r);
        int   n = d ? 512 : 8;
        int   l = d ? 9 : 3;
        exp_t e;
        if (fcnt[d] == 0) frev[d] = r;
        frm[d][fcnt[d]] = v;
        fcnt[d]++;
        if (fcnt[d] == n) begin
            for (int j = 0; j < n; j++) begin
                e.idx  = frev[d] ? brev(j, l) : j;
                e.data = frm[d][e.idx];
                e.last = (j == n - 1);
                if (d == 1) q9.push_back(e);
                else q3.push_back(e);
            end
            fcnt[d] = 0;
        end
    endtask

    task automatic send3(logic [31:0] v, logic r);
        int n = 0;
        in_valid3 = 1'b1;
        in_data3  = v;
        rev3      = r;
        @(negedge clk);
        while (!in_ready3 && n < 5000) begin
            n++;
            waits3++;
            @(negedge clk);
        end
        if (!in_ready3) begin
            chk("send3_timeout", 0, 1);
            in_valid3 = 1'b0;
        end else begin
            model_accept(0, v, r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send9(logic [31:0] v, logic r);
        int n = 0;
        in_valid9 = 1'b1;
        in_data9  = v;
        rev9      = r;
        @(negedge clk);
        while (!in_ready9 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready9) begin
            chk("send9_timeout", 0, 1);
            in_valid9 = 1'b0;
        end else begin
            model_accept(1, v, r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain3(string nm);
        int n = 0;
        in_valid3 = 1'b0;
        while ((q3.size() != 0 || out_valid3) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain"}, q3.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain9(string nm);
        int n = 0;
        in_valid9 = 1'b0;
        while ((q9.size() != 0 || out_valid9) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain"}, q9.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 8-point instance: scoreboard pop, hold-stable and
    // output-gap tracking.
    initial begin
        exp_t        e;
        bit          hold = 0;
        logic [31:0] hd;
        logic [2:0]  hi;
        logic        hl;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("hold3_valid", out_valid3, 1);
                    chk("hold3_data", out_data3, hd);
                    chk("hold3_idx", out_idx3, hi);
                    chk("hold3_last", out_last3, hl);
                end
                if (gap_en && seen3 && q3.size() > 0 && !out_valid3) gaps++;
                if (out_valid3) seen3 = 1;
                if (out_valid3 && out_ready3) begin
                    if (q3.size() == 0) begin
                        chk("out3_unexpected", 1, 0);
                    end else begin
                        e = q3.pop_front();
                        chk("out3_data", out_data3, e.data);
                        chk("out3_idx", out_idx3, e.idx);
                        chk("out3_last", out_last3, e.last);
                    end
                end
                hold = out_valid3 && !out_ready3;
                hd   = out_data3;
                hi   = out_idx3;
                hl   = out_last3;
            end
        end
    end

    initial begin
        exp_t        e;
        bit          hold = 0;
        logic [31:0] hd;
        logic [8:0]  hi;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("hold9_valid", out_valid9, 1);
                    chk("hold9_data", out_data9, hd);
                    chk("hold9_idx", out_idx9, hi);
                end
                if (out_valid9 && out_ready9) begin
                    if (q9.size() == 0) begin
                        chk("out9_unexpected", 1, 0);
                    end else begin
                        e = q9.pop_front();
                        chk("out9_data", out_data9, e.data);
                        chk("out9_idx", out_idx9, e.idx);
                        chk("out9_last", out_last9, e.last);
                    end
                end
                hold = out_valid9 && !out_ready9;
                hd   = out_data9;
                hi   = out_idx9;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd3) out_ready3 = 1'($urandom_range(0, 1));
            if (rnd9) out_ready9 = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fcnt[0] = 0;
        fcnt[1] = 0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", out_valid3, 0);
        chk("rst_data", out_data3, 0);
        chk("rst_idx", out_idx3, 0);
        chk("rst_last", out_last3, 0);
        chk("rst_in_ready3", in_ready3, 0);
        chk("rst_in_ready9", in_ready9, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready3", in_ready3, 1);
        chk("post_rst_in_ready9", in_ready9, 1);
        @(posedge clk);
        #1;

        // Reversed 0..7 and first-word latency
        for (int i = 0; i < 8; i++) send3(i, 1'b1);
        in_valid3 = 1'b0;
        chk("t1_lat_pre", out_valid3, 0);
        @(posedge clk);
        #1;
        chk("t1_latency", out_valid3, 1);
        chk("t1_first", out_data3, 0);
        drain3("t1");

        // Reversed frame then natural frame, rev_en wiggled mid-frame
        for (int i = 0; i < 8; i++) send3(i, (i == 0) ? 1'b1 : 1'(i % 2));
        for (int i = 0; i < 8; i++) send3(8 + i, (i == 0) ? 1'b0 : 1'((i + 1) % 2));
        drain3("t2");

        // Three back-to-back frames: no input stalls, no output bubbles
        waits3 = 0;
        gaps   = 0;
        seen3  = 0;
        gap_en = 1;
        for (int f = 0; f < 3; f++) begin
            logic r;
            r = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) send3($urandom, r);
        end
        drain3("t3");
        gap_en = 0;
        chk("t3_in_waits", waits3, 0);
        chk("t3_out_gaps", gaps, 0);

        // Both banks full under backpressure
        out_ready3 = 1'b0;
        for (int i = 0; i < 16; i++) send3(i, 1'b1);
        in_valid3 = 1'b0;
        chk("t4_in_ready_full", in_ready3, 0);
        chk("t4_valid", out_valid3, 1);
        chk("t4_data0", out_data3, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_in_ready_hold", in_ready3, 0);
        chk("t4_data_hold", out_data3, 0);
        out_ready3 = 1'b1;
        drain3("t4");

        // Reset mid-frame with a stalled output pending
        out_ready3 = 1'b0;
        for (int i = 0; i < 8; i++) send3(8 + i, 1'b1);
        for (int i = 0; i < 5; i++) send3(20 + i, 1'b1);
        in_valid3 = 1'b0;
        chk("t5_pre_valid", out_valid3, 1);
        chk("t5_pre_data", out_data3, 8);
        reset = 1'b1;
        q3.delete();
        q9.delete();
        fcnt[0] = 0;
        fcnt[1] = 0;
        #1;
        chk("t5_rst_valid", out_valid3, 0);
        chk("t5_rst_data", out_data3, 0);
        chk("t5_rst_idx", out_idx3, 0);
        chk("t5_rst_last", out_last3, 0);
        chk("t5_rst_in_ready", in_ready3, 0);
        @(negedge clk);
        chk("t5_rst_in_ready2", in_ready3, 0);
        out_ready3 = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) send3(i, 1'b1);
        drain3("t5");

        // Random frames, gaps and consumer stalls on the 8-point buffer
        rnd3 = 1;
        for (int f = 0; f < 6; f++) begin
            logic r;
            r = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                send3($urandom, (i == 0) ? r : 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) begin
                    in_valid3 = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        end
        in_valid3 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rnd3 = 0;
        out_ready3 = 1'b1;
        drain3("t6");

        // 512-point random frames with stalls
        rnd9 = 1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 512; i++) begin
                send9($urandom, (f != 1));
                if ($urandom_range(0, 15) == 0) begin
                    in_valid9 = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid9 = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rnd9 = 0;
        out_ready9 = 1'b1;
        drain9("t7");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/bitrev_buffer.md
# bitrev_buffer

Streaming bit-reversal reorder buffer for the FFT datapath. It accepts frames of 2^LOG2N samples in natural order and emits each frame in bit-reversed index order, or in natural order when reversal is disabled for that frame. It sits between the sample source and the radix-2 butterfly stages. Ping-pong banking sustains one sample per clock in and out.

## Interface
Parameters:
- LOG2N, default 9: log2 of the frame length (default 512 points); legal range 1 to 12.
- W, default 32: sample width in bits (default is 16-bit real and 16-bit imaginary packed).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a sample.
- in_ready  output  1  buffer can accept a sample; a sample transfers on a rising edge where in_valid and in_ready are both 1.
- in_data  input  W  input sample, natural order.
- rev_en  input  1  reversal enable; sampled on the first accepted sample of each frame.
- out_valid  output  1  out_data, out_idx and out_last are valid.
- out_ready  input  1  consumer accepts output; a transfer occurs on a rising edge where out_valid and out_ready are both 1.
- out_data  output  W  output sample.
- out_idx  output  LOG2N  natural-order index of out_data within its frame.
- out_last  output  1  high with the final sample of a frame.

## Operation
- Storage is two banks (bank 0 and bank 1) of 2^LOG2N words of W bits each. Each bank has a full flag and a stored rev_en bit.
- Write side:
  - State is wbank (the bank being filled) and wcnt (LOG2N bits).
  - in_ready = !full[wbank], forced to 0 while reset is high.
  - On each accepted sample, mem[wbank][wcnt] <= in_data and wcnt increments.
  - When wcnt = 0, the same edge also captures rev_en into mode[wbank].
  - When wcnt = 2^LOG2N−1, the same edge sets full[wbank], toggles wbank and wraps wcnt to 0.
- Read side:
  - State is rbank, rcnt (LOG2N bits) and a registered output stage.
  - advance = !out_valid || out_ready.
  - If advance is 1 and full[rbank] is 1:
    - raddr = rcnt bit-reversed when mode[rbank] = 1, otherwise rcnt.
    - out_data <= mem[rbank][raddr], out_idx <= raddr, out_last <= (rcnt = 2^LOG2N−1), out_valid <= 1.
    - rcnt increments.
    - On the last word, the same edge clears full[rbank], toggles rbank and wraps rcnt.
  - If advance is 1 and full[rbank] is 0: out_valid <= 0, and out_data, out_idx and out_last are left unchanged.
  - If advance is 0, all output registers hold.
- Bit reversal: output bit b of raddr = rcnt bit LOG2N−1−b, for every LOG2N.
- Simultaneous events on one edge:
  - The writer setting full on one bank and the reader clearing full on the other bank are independent and both take effect.
  - The writer never writes a bank whose full flag is set.
- Frame alignment is purely count-based; there is no input framing signal.

## Timing
- Reset values (asynchronous):
  - All output registers: out_valid=0, out_data=0, out_idx=0, out_last=0.
  - full[1:0]=0, mode=0, wbank=rbank=0, wcnt=rcnt=0.
  - in_ready=0 while reset is high, and 1 in the first cycle after release.
  - Memory contents are not cleared.
- Latency: if the last sample of a frame is accepted on edge k and the output side is idle, out_valid rises on edge k+1 with the frame's first word.
- Throughput with continuous in_valid and out_ready=1:
  - The reader drains the bank on edges k+1 to k+2^LOG2N.
  - The writer fills the other bank over the same edges.
  - Both sides sustain one word per cycle with no bubbles after the first frame.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
  - When both banks are full, in_ready=0.
- Reset asserted mid-frame: all in-flight and partial frames are discarded and the first post-reset sample is frame index 0.

## Test plan
- LOG2N=3, rev_en=1, input values 0..7 back-to-back, out_ready=1 → out_data sequence 0,4,2,6,1,5,3,7 with out_idx equal to the data; out_last=1 only on the 7; out_valid rises one edge after input 7 is accepted.
- LOG2N=3, frame A with rev_en=1 followed directly by frame B with rev_en=0 (values 8..15) → A reversed, then B emitted as 8..15; rev_en toggled mid-frame has no effect.
- LOG2N=3, three continuous frames, out_ready=1 → in_ready never drops after reset; 24 outputs with out_valid continuous from the first output.
- LOG2N=3, out_ready=0 throughout → in_ready drops after 16 accepted samples and out_data holds at 0; then out_ready=1 → all 16 samples emerge in correct order with no loss or duplication.
- Assert reset after 5 samples of a frame → all outputs go to 0 immediately and in_ready=0 during reset; a subsequent full frame 0..7 yields 0,4,2,6,1,5,3,7.
- LOG2N=9, W=32, random data with rev_en=1 → output j equals input bitrev9(j) (e.g. output 1 = input 256, output 511 = input 511), checked against a scoreboard.
